// File: rtl/f1_reaction_timer.sv
// -----------------------------------------------------------------------------
// f1_reaction_timer
//
// Consumer-side companion to the F1 start-light sequencer. Watches the 8-bit
// light bar, recognises a legal build-up to a full bar (8'hFF) followed by
// lights-out (8'h00), then counts cycles until the driver's trigger rises.
// Reports the reaction count, or flags a jump start if the trigger rises while
// the lights are still on.
//
// Optional feature macro: F1_TIMER_PRESCALE_EN
//   When defined, a PRESCALE-cycle prescaler runs in RUNNING and the reaction
//   count advances once per prescaler wrap. When undefined, there is no
//   prescaler, the count advances every RUNNING cycle and PRESCALE is unused.
//
// Parameters:
//   WIDTH     width of the reaction counter and time_out
//   PRESCALE  cycles per count tick (prescale build only)
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset, clears all state while low
//   lights      light bar from the sequencer
//   trigger     driver button (level, already synchronous to clk)
//   time_out    last measured reaction count, held until the next result
//   valid       one-cycle pulse when time_out is updated
//   jump_start  high while in JUMP
//   busy        high in FILLING, ARMED and RUNNING
//   dbg_state   current FSM state encoding, for observation only
//
// Handshake: valid is a single-cycle strobe with no ready/back-pressure; the
// consumer must capture time_out on the cycle valid is high (time_out also
// stays stable afterwards until the next result or reset).
// -----------------------------------------------------------------------------
module f1_reaction_timer #(
   parameter int WIDTH    = 16,
   parameter int PRESCALE = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       lights,
   input  logic             trigger,
   output logic [WIDTH-1:0] time_out,
   output logic             valid,
   output logic             jump_start,
   output logic             busy,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FILLING = 3'd1,
      S_ARMED   = 3'd2,
      S_RUNNING = 3'd3,
      S_DONE    = 3'd4,
      S_JUMP    = 3'd5
   } state_t;

   state_t           state;
   state_t           state_n;
   logic             trig_q;
   logic             rise;
   logic             tick;
   logic [WIDTH-1:0] count;

   // A prescale of zero cycles has no meaning.
   if (PRESCALE < 1) begin : g_prescale_check
      $error("f1_reaction_timer: PRESCALE must be at least 1");
   end

   // Only a fresh press acts; a held button is ignored everywhere.
   assign rise = trigger & ~trig_q;

`ifdef F1_TIMER_PRESCALE_EN
   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PS_W-1:0] prescaler;

   // The count advances on the cycle the prescaler wraps PRESCALE-1 -> 0.
   assign tick = (prescaler == PS_W'(PRESCALE - 1));
`else
   assign tick = 1'b1;
`endif

   // Next-state decode. Trigger rises take priority over light changes so a
   // press on the same edge as lights-out is always a jump start.
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE: begin
            if (lights != 8'h00) state_n = S_FILLING;
         end
         S_FILLING: begin
            if (rise)                  state_n = S_JUMP;
            else if (lights == 8'hFF)  state_n = S_ARMED;
            else if (lights == 8'h00)  state_n = S_IDLE;
         end
         S_ARMED: begin
            if (rise)                  state_n = S_JUMP;
            else if (lights == 8'h00)  state_n = S_RUNNING;
         end
         S_RUNNING: begin
            // The light bar is deliberately ignored while timing.
            if (rise) state_n = S_DONE;
         end
         S_DONE: begin
            if (!trigger) state_n = S_IDLE;
         end
         S_JUMP: begin
            // Leave only once the button is released and the bar is dark.
            if (!trigger && (lights == 8'h00)) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         trig_q     <= 1'b0;
         count      <= '0;
         time_out   <= '0;
         valid      <= 1'b0;
         jump_start <= 1'b0;
         busy       <= 1'b0;
`ifdef F1_TIMER_PRESCALE_EN
         prescaler  <= '0;
`endif
      end else begin
         state      <= state_n;
         trig_q     <= trigger;
         valid      <= 1'b0;
         // Status outputs follow the state being entered, so they line up
         // exactly with the registered state.
         busy       <= (state_n == S_FILLING) || (state_n == S_ARMED) ||
                       (state_n == S_RUNNING);
         jump_start <= (state_n == S_JUMP);

         if ((state == S_ARMED) && (state_n == S_RUNNING)) begin
            // Lights-out: start a fresh measurement.
            count     <= '0;
`ifdef F1_TIMER_PRESCALE_EN
            prescaler <= '0;
`endif
         end else if (state == S_RUNNING) begin
            if (rise) begin
               time_out <= count;
               valid    <= 1'b1;
            end else begin
`ifdef F1_TIMER_PRESCALE_EN
               prescaler <= tick ? '0 : prescaler + PS_W'(1);
`endif
               // Saturate rather than wrap so a very slow driver reads max.
               if (tick && (count != {WIDTH{1'b1}})) begin
                  count <= count + WIDTH'(1);
               end
            end
         end
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_f1_reaction_timer.sv
// -----------------------------------------------------------------------------
// tb_f1_reaction_timer
//
// Directed bench for f1_reaction_timer (WIDTH=4, PRESCALE=4). A behavioural
// model tracks the phase of the start procedure and derives the reaction
// value from elapsed cycles since lights-out; a compare process checks every
// output on every falling edge, a queue holds the expected time_out of each
// valid pulse, and literal checks pin the model at key points.
// -----------------------------------------------------------------------------
module tb_f1_reaction_timer;

   localparam int WIDTH    = 4;
   localparam int PRESCALE = 4;
   localparam int MAXV     = (1 << WIDTH) - 1;
`ifdef F1_TIMER_PRESCALE_EN
   localparam int P = PRESCALE;
`else
   localparam int P = 1;
`endif

   // ---------------- clock / reset ----------------
   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [7:0]       lights = 8'h00;
   logic             trigger = 1'b0;
   logic [WIDTH-1:0] time_out;
   logic             valid;
   logic             jump_start;
   logic             busy;
   logic [2:0]       dbg_state;

   always #5 clk = ~clk;

   f1_reaction_timer #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
      .clk        (clk),
      .rst        (rst),
      .lights     (lights),
      .trigger    (trigger),
      .time_out   (time_out),
      .valid      (valid),
      .jump_start (jump_start),
      .busy       (busy),
      .dbg_state  (dbg_state)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum {M_IDLE, M_BUILD, M_FULL, M_TIMING, M_RESULT, M_FOUL} phase_t;

   phase_t           m_phase = M_IDLE;
   bit               m_prev = 0;
   bit               m_rise;
   bit               m_valid = 0;
   int               m_time = 0;
   int               m_cyc = 0;
   int               m_lo = 0;
   logic [WIDTH-1:0] exp_q[$];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_phase = M_IDLE;
         m_prev  = 0;
         m_valid = 0;
         m_time  = 0;
      end else begin
         int k;
         int t;
         m_cyc++;
         m_rise  = trigger && !m_prev;
         m_prev  = trigger;
         m_valid = 0;
         case (m_phase)
            M_IDLE:   if (lights != 0) m_phase = M_BUILD;
            M_BUILD:  if (m_rise) m_phase = M_FOUL;
                      else if (lights == 8'hFF) m_phase = M_FULL;
                      else if (lights == 8'h00) m_phase = M_IDLE;
            M_FULL:   if (m_rise) m_phase = M_FOUL;
                      else if (lights == 8'h00) begin
                         m_phase = M_TIMING;
                         m_lo    = m_cyc;
                      end
            M_TIMING: if (m_rise) begin
                         k = m_cyc - m_lo;
                         t = (k - 1) / P;
                         if (t > MAXV) t = MAXV;
                         m_time  = t;
                         m_valid = 1;
                         exp_q.push_back(WIDTH'(t));
                         m_phase = M_RESULT;
                      end
            M_RESULT: if (!trigger) m_phase = M_IDLE;
            M_FOUL:   if (!trigger && lights == 8'h00) m_phase = M_IDLE;
            default:  m_phase = M_IDLE;
         endcase
      end
   end

   // ---------------- compare / scoreboard ----------------
   always @(negedge clk) begin
      if (rst) begin
         chk("time_out", int'(time_out), m_time);
         chk("valid", int'(valid), int'(m_valid));
         chk("jump_start", int'(jump_start), int'(m_phase == M_FOUL));
         chk("busy", int'(busy), int'(m_phase == M_BUILD || m_phase == M_FULL ||
                                      m_phase == M_TIMING));
         if (valid) begin
            if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
            else chk("result_q", int'(time_out), int'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [7:0] l, input logic t);
      lights  = l;
      trigger = t;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic build(input logic t);
      logic [7:0] l;
      l = 8'h00;
      for (int i = 0; i < 8; i++) begin
         l = {l[6:0], 1'b1};
         drive(l, t);
      end
   endtask

   // Lights-out at E0, then the first rise at E0+k.
   task automatic react(input int k);
      drive(8'h00, 1'b0);
      for (int i = 1; i < k; i++) drive(8'h00, 1'b0);
      drive(8'h00, 1'b1);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      // Reset with a lit bar: outputs must read zero, FILLING at first edge.
      lights = 8'h01;
      repeat (2) @(negedge clk);
      chk("rst_time_out", int'(time_out), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_jump", int'(jump_start), 0);
      chk("rst_busy", int'(busy), 0);
      #1 rst = 1'b1;
      drive(8'h03, 1'b0);
      chk("lit_release_busy", int'(busy), 1);
      drive(8'h00, 1'b0);
      chk("lit_release_abort", int'(busy), 0);

      // Normal start, rise at E0+10.
      build(1'b0);
      react(10);
`ifdef F1_TIMER_PRESCALE_EN
      chk("normal_time", int'(time_out), 2);
`else
      chk("normal_time", int'(time_out), 9);
`endif
      chk("normal_valid", int'(valid), 1);
      chk("normal_busy", int'(busy), 0);
      chk("normal_jump", int'(jump_start), 0);
      drive(8'h00, 1'b1);
      chk("normal_valid_once", int'(valid), 0);
      drive(8'h00, 1'b0);

      // Jump while armed; result register untouched.
      build(1'b0);
      drive(8'hFF, 1'b1);
      chk("armed_jump", int'(jump_start), 1);
`ifdef F1_TIMER_PRESCALE_EN
      chk("armed_jump_time_kept", int'(time_out), 2);
`else
      chk("armed_jump_time_kept", int'(time_out), 9);
`endif
      drive(8'hFF, 1'b0);
      chk("jump_hold_lights_on", int'(jump_start), 1);
      drive(8'h00, 1'b0);
      chk("jump_release", int'(jump_start), 0);

      // Rise on the same edge as lights-out.
      build(1'b0);
      drive(8'h00, 1'b1);
      chk("simul_jump", int'(jump_start), 1);
      chk("simul_no_valid", int'(valid), 0);
      drive(8'h00, 1'b0);

      // Aborted build-up.
      drive(8'h01, 1'b0);
      chk("abort_busy_hi", int'(busy), 1);
      drive(8'h03, 1'b0);
      drive(8'h00, 1'b0);
      chk("abort_busy_lo", int'(busy), 0);
      chk("abort_no_jump", int'(jump_start), 0);

      // Saturation: rise 41 edges after lights-out.
      build(1'b0);
      react(41);
`ifdef F1_TIMER_PRESCALE_EN
      chk("sat_time", int'(time_out), 10);
`else
      chk("sat_time", int'(time_out), 15);
`endif
      chk("sat_valid", int'(valid), 1);
      drive(8'h00, 1'b0);

      // Fastest legal reaction: rise at E0+1.
      build(1'b0);
      react(1);
      chk("fast_time", int'(time_out), 0);
      drive(8'h00, 1'b0);

      // Asynchronous reset mid-RUNNING.
      build(1'b0);
      react_partial();
      chk("areset_time_out", int'(time_out), 0);
      chk("areset_valid", int'(valid), 0);
      chk("areset_busy", int'(busy), 0);
      chk("areset_jump", int'(jump_start), 0);
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      drive(8'h00, 1'b1);
      chk("post_reset_idle", int'(busy), 0);
      chk("post_reset_no_valid", int'(valid), 0);
      // Held trigger through a whole new sequence must not count as a press.
      build(1'b1);
      chk("held_no_jump", int'(jump_start), 0);
      drive(8'h00, 1'b1);
      for (int i = 0; i < 4; i++) drive(8'h00, 1'b0);
      drive(8'h00, 1'b1);
`ifdef F1_TIMER_PRESCALE_EN
      chk("post_reset_time", int'(time_out), 1);
`else
      chk("post_reset_time", int'(time_out), 4);
`endif
      chk("post_reset_valid", int'(valid), 1);
      drive(8'h00, 1'b0);
      drive(8'h00, 1'b0);

      chk("exp_q_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   // Lights-out plus a few timing edges, then reset between clock edges.
   task automatic react_partial();
      drive(8'h00, 1'b0);
      for (int i = 0; i < 3; i++) drive(8'h00, 1'b0);
      @(posedge clk);
      #2 rst = 1'b0;
      trigger = 1'b1;
      #1;
   endtask

endmodule

// File: doc/f1_reaction_timer.md
# f1_reaction_timer

Consumer-side companion to the F1 start-light sequencer. Watches the 8-bit light bar the sequencer drives, recognises a legal full-bar build-up followed by lights-out, then measures the cycles until the driver's trigger. Reports a reaction time, or flags a jump start if the trigger fires while the lights are still on. Sits between the light sequencer output and the display/scoring logic.

## Interface
- WIDTH, 16, width of the reaction counter and `time_out`.
- PRESCALE, 1000, cycles per count tick; used only when `F1_TIMER_PRESCALE_EN` is defined.

- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low; all state cleared immediately while low.
- lights  input  8  light bar from the sequencer; legal values are 8'h00 and 8'h01, 8'h03, 8'h07 through 8'hFF.
- trigger  input  1  driver button, level, already synchronised to `clk`.
- time_out  output  WIDTH  last measured reaction count.
- valid  output  1  one-cycle pulse when `time_out` is updated.
- jump_start  output  1  level, high while in JUMP.
- busy  output  1  high in FILLING, ARMED and RUNNING.

## Operation
- Edge detect: `trig_q` registers `trigger`. rise = trigger & ~trig_q. Only rises act; a held trigger does nothing.
- States and transitions, evaluated at each rising `clk`:
  - IDLE: lights != 0 -> FILLING. Otherwise stay.
  - FILLING:
    - rise -> JUMP.
    - Else lights == 8'hFF -> ARMED.
    - Else lights == 8'h00 -> IDLE (aborted sequence).
    - Otherwise stay.
  - ARMED:
    - rise -> JUMP. This has priority over lights-out on the same edge.
    - Else lights == 8'h00 -> RUNNING, count <= 0.
    - Otherwise stay.
  - RUNNING:
    - rise -> DONE, time_out <= count, valid <= 1.
    - Otherwise count increments, saturating at all-ones.
    - `lights` is ignored in this state.
  - DONE: trigger == 0 -> IDLE. Otherwise stay.
  - JUMP: trigger == 0 and lights == 8'h00 -> IDLE. Otherwise stay.
- `time_out` holds its value until the next DONE entry or reset. A jump does not modify it.
- `valid` is high for exactly the one cycle after the RUNNING->DONE edge.
- Counter saturation: at 2^WIDTH-1 the count holds. A later rise reports 2^WIDTH-1.
- Unused encoding / default -> IDLE.

## Timing
- Reset values:
  - state IDLE.
  - count 0, trig_q 0, prescaler 0.
  - time_out 0, valid 0, jump_start 0, busy 0.
- All outputs are registered or decoded from the state register. There is no combinational path from input to output.
- Reaction latency:
  - Let E0 be the edge at which ARMED samples lights == 0.
  - If the first rise is sampled at edge E0+k (k >= 1), then time_out = k-1. This is without prescale.
  - `valid` is high in the cycle after E0+k.
- A rise sampled at E0 itself counts as a jump.
- Reset asserted mid-RUNNING: count is lost and no `valid` pulse is produced. After release, the block sits in IDLE and needs a fresh build-up.
- `lights` is nonzero at reset release: the block goes to FILLING at the first edge.

## Configuration
- `F1_TIMER_PRESCALE_EN` defined:
  - A PRESCALE-cycle prescaler runs only in RUNNING. It is cleared on ARMED->RUNNING.
  - count increments only on the cycle the prescaler wraps (PRESCALE-1 -> 0).
  - time_out is in units of PRESCALE cycles, truncated.
- Not defined: no prescaler logic, count increments every RUNNING cycle, PRESCALE ignored.

## Test plan
- Normal start, no prescale:
  - Stimulus: lights 00,01,03,…,FF, then 00 sampled at E0; trigger rises at E0+10.
  - Response: time_out=9, valid pulse one cycle, busy falls, jump_start=0.
- Jump in ARMED: lights held FF, trigger rises -> jump_start=1. It stays 1 until trigger=0 and lights=00, then IDLE. time_out is unchanged from the previous value.
- Simultaneous: trigger rise and lights FF->00 on the same edge -> JUMP, no valid.
- Abort in FILLING: lights 01,03 then 00 -> back to IDLE, busy 1->0, no valid, no jump.
- Saturation with WIDTH=4: no trigger for 40 cycles after lights-out, then a rise -> time_out=15, valid=1.
- Async reset mid-RUNNING: rst low between edges -> all outputs 0 immediately; after release, a held trigger does not fire, and a new sequence measures correctly.
- With `F1_TIMER_PRESCALE_EN`, PRESCALE=4, rise at E0+10 -> time_out=2.
